// File: rtl/tick_divider.sv
// Clock-enable divider: one-cycle tick every N enabled cycles, toggled clk_out and wrapping tick count.
// Define TICK_DIVIDER_GLITCHLESS_LOAD_EN to defer divisor loads to the next wrap edge.
module tick_divider #(
  parameter int               WIDTH       = 25,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = 25'd25000000,
  parameter int               TICK_W      = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              div_load,
  input  logic [WIDTH-1:0]  div_value,
  output logic              tick,
  output logic              clk_out,
  output logic [WIDTH-1:0]  count,
  output logic [TICK_W-1:0] ticks
);

  logic [WIDTH-1:0]  div_q, div_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic              clk_q, clk_d;
  logic [TICK_W-1:0] ticks_q, ticks_d;
  logic [WIDTH-1:0]  last_cnt;
  logic              wrap;

`ifdef TICK_DIVIDER_GLITCHLESS_LOAD_EN
  logic [WIDTH-1:0]  pend_div_q, pend_div_d;
  logic              pend_vld_q, pend_vld_d;
`endif

  // A zero divisor behaves as N=1, so the last count value is 0 either way.
  assign last_cnt = (div_q == '0) ? '0 : div_q - 1'b1;
  assign wrap     = en && (cnt_q == last_cnt);

  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    clk_d   = clk_q;
    ticks_d = ticks_q;
`ifdef TICK_DIVIDER_GLITCHLESS_LOAD_EN
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;
    if (sync_clr) begin
      cnt_d      = '0;
      clk_d      = 1'b0;
      ticks_d    = '0;
      pend_vld_d = 1'b0;
      if (div_load)
        div_d = div_value;
      else if (pend_vld_q)
        div_d = pend_div_q;
    end else if (wrap) begin
      cnt_d      = '0;
      tick_d     = 1'b1;
      clk_d      = ~clk_q;
      ticks_d    = ticks_q + 1'b1;
      pend_vld_d = 1'b0;
      // The divisor only changes at a period boundary, keeping clk_out half-periods whole.
      if (div_load)
        div_d = div_value;
      else if (pend_vld_q)
        div_d = pend_div_q;
    end else begin
      if (en)
        cnt_d = cnt_q + 1'b1;
      if (div_load) begin
        pend_div_d = div_value;
        pend_vld_d = 1'b1;
      end
    end
`else
    if (sync_clr) begin
      cnt_d   = '0;
      clk_d   = 1'b0;
      ticks_d = '0;
      if (div_load)
        div_d = div_value;
    end else if (div_load) begin
      div_d = div_value;
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d   = '0;
      tick_d  = 1'b1;
      clk_d   = ~clk_q;
      ticks_d = ticks_q + 1'b1;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      div_q   <= DEFAULT_DIV;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      clk_q   <= 1'b0;
      ticks_q <= '0;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      clk_q   <= clk_d;
      ticks_q <= ticks_d;
    end
  end

`ifdef TICK_DIVIDER_GLITCHLESS_LOAD_EN
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)
      pend_vld_q <= 1'b0;
    else
      pend_vld_q <= pend_vld_d;
  end

  // Pending value is only meaningful while pend_vld_q is set, so it needs no reset.
  always_ff @(posedge clock) begin
    pend_div_q <= pend_div_d;
  end
`endif

  assign tick    = tick_q;
  assign clk_out = clk_q;
  assign count   = cnt_q;
  assign ticks   = ticks_q;

endmodule
